// File: rtl/matrix_alu_seq.sv
// matrix_alu_seq: sequential NxN signed matrix ALU on a shared memory-mapped bus.
// The host loads SRC1/SRC2, writes an opcode to CMD, and a start/busy/done FSM
// produces one result element (ADD/SUB/TRN/SCL) or one multiply-accumulate (MUL)
// per clock. RESULT and STATUS are read back combinationally over dataBus.
// Optional feature: define MATRIX_ALU_SAT_EN to saturate every written element
// to the signed W-bit range and report overflow in STATUS[3]; otherwise results wrap.
module matrix_alu_seq #(
  parameter int N = 4,
  parameter int W = 16,
  parameter logic [15:0] BASE = 16'h2000
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [15:0]       address,
  input  logic              nRead,
  input  logic              nWrite,
  inout  wire  [N*N*W-1:0]  dataBus
);

  localparam int BUS_W = N * N * W;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int IW    = $clog2(BUS_W);
  localparam int FW    = 2 * W + $clog2(N) + 1;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [15:0] ADDR_SRC1 = BASE;
  localparam logic [15:0] ADDR_SRC2 = BASE + 16'h0001;
  localparam logic [15:0] ADDR_RES  = BASE + 16'h0D00;
  localparam logic [15:0] ADDR_CMD  = BASE + 16'h0E00;
  localparam logic [15:0] ADDR_STAT = BASE + 16'h0F00;

  localparam logic [15:0] OP_MUL = 16'h2100;
  localparam logic [15:0] OP_ADD = 16'h2400;
  localparam logic [15:0] OP_SUB = 16'h2500;
  localparam logic [15:0] OP_TRN = 16'h2600;
  localparam logic [15:0] OP_SCL = 16'h2700;

  localparam logic signed [FW-1:0] SAT_MAX = {{(FW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [FW-1:0] SAT_MIN = {{(FW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [BUS_W-1:0] src1;
  logic [BUS_W-1:0] src2;
  logic [BUS_W-1:0] result;
  logic [15:0]      op;
  logic [CW-1:0]    row;
  logic [CW-1:0]    col;
  logic [CW-1:0]    kk;
  logic signed [FW-1:0] acc;
  logic             err;
  logic             ovf;

  logic             cmd_wr;
  logic             src1_wr;
  logic             src2_wr;
  logic             op_valid;
  logic             accept;
  logic             write_elem;
  logic             last_step;

  logic [IW-1:0]    base_rc;
  logic [IW-1:0]    base_cr;
  logic [IW-1:0]    base_rk;
  logic [IW-1:0]    base_kc;
  logic signed [FW-1:0] x_a;
  logic signed [FW-1:0] x_b;
  logic signed [FW-1:0] x_t;
  logic signed [FW-1:0] x_s;
  logic signed [FW-1:0] x_ma;
  logic signed [FW-1:0] x_mb;
  logic signed [FW-1:0] full;
  logic [W-1:0]     elem;
  logic             elem_ovf;
  logic             unused_hi;

  logic [BUS_W-1:0] status_word;
  logic [BUS_W-1:0] rd_data;
  logic             rd_en;

  assign src1_wr = !nWrite && (address == ADDR_SRC1);
  assign src2_wr = !nWrite && (address == ADDR_SRC2);
  assign cmd_wr  = !nWrite && (address == ADDR_CMD);

  assign op_valid = (dataBus[15:0] == OP_MUL) || (dataBus[15:0] == OP_ADD) ||
                    (dataBus[15:0] == OP_SUB) || (dataBus[15:0] == OP_TRN) ||
                    (dataBus[15:0] == OP_SCL);

  // A command only starts a new operation when the engine is not running.
  assign accept     = cmd_wr && op_valid && (state != S_RUN);
  assign write_elem = (state == S_RUN) && ((op != OP_MUL) || (kk == LAST));
  assign last_step  = write_elem && (row == LAST) && (col == LAST);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state: start on an accepted command, finish after the last element.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (accept)    state_next = S_RUN;
      S_RUN:          if (last_step) state_next = S_DONE;
      default:                       state_next = S_IDLE;
    endcase
  end

  // Operand selection and full-precision element value for the current step.
  always_comb begin
    base_rc = IW'((int'(row) * N + int'(col)) * W);
    base_cr = IW'((int'(col) * N + int'(row)) * W);
    base_rk = IW'((int'(row) * N + int'(kk)) * W);
    base_kc = IW'((int'(kk) * N + int'(col)) * W);
    x_a  = FW'($signed(src1[base_rc +: W]));
    x_b  = FW'($signed(src2[base_rc +: W]));
    x_t  = FW'($signed(src1[base_cr +: W]));
    x_s  = FW'($signed(src2[W-1:0]));
    x_ma = FW'($signed(src1[base_rk +: W]));
    x_mb = FW'($signed(src2[base_kc +: W]));
    full = '0;
    case (op)
      OP_ADD:  full = x_a + x_b;
      OP_SUB:  full = x_a - x_b;
      OP_TRN:  full = x_t;
      OP_SCL:  full = x_a * x_s;
      OP_MUL:  full = acc + x_ma * x_mb;
      default: full = '0;
    endcase
  end

  // Reduce the full-precision value to W bits (saturate or wrap).
  always_comb begin
    elem     = full[W-1:0];
    elem_ovf = 1'b0;
`ifdef MATRIX_ALU_SAT_EN
    if (full > SAT_MAX) begin
      elem     = {1'b0, {(W-1){1'b1}}};
      elem_ovf = 1'b1;
    end else if (full < SAT_MIN) begin
      elem     = {1'b1, {(W-1){1'b0}}};
      elem_ovf = 1'b1;
    end
`endif
  end

  // Upper bits only matter for saturation; keep them visibly consumed.
  assign unused_hi = ^{full[FW-1:W], SAT_MAX[0], SAT_MIN[0]};

  // Register file, command handling and the per-clock element engine.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      src1   <= '0;
      src2   <= '0;
      result <= '0;
      op     <= '0;
      row    <= '0;
      col    <= '0;
      kk     <= '0;
      acc    <= '0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (src1_wr && state != S_RUN) src1 <= dataBus;
      if (src2_wr && state != S_RUN) src2 <= dataBus;
      if (accept) begin
        op     <= dataBus[15:0];
        result <= '0;
        row    <= '0;
        col    <= '0;
        kk     <= '0;
        acc    <= '0;
        err    <= 1'b0;
        ovf    <= 1'b0;
      end else begin
        if (cmd_wr) err <= 1'b1;
        if (state == S_RUN) begin
          if (!write_elem) begin
            acc <= full;
            kk  <= kk + 1'b1;
          end else begin
            result[base_rc +: W] <= elem;
            ovf <= ovf | elem_ovf;
            acc <= '0;
            kk  <= '0;
            if (col == LAST) begin
              col <= '0;
              row <= (row == LAST) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
      end
    end
  end

  // STATUS layout: done, busy, err, ovf in the low nibble, N in [15:8].
  always_comb begin
    status_word       = '0;
    status_word[0]    = (state == S_DONE);
    status_word[1]    = (state == S_RUN);
    status_word[2]    = err;
    status_word[3]    = ovf;
    status_word[15:8] = 8'(N);
  end

  // The bus is driven only for readable registers and never during a write.
  assign rd_en   = !nRead && nWrite && ((address == ADDR_RES) || (address == ADDR_STAT));
  assign rd_data = (address == ADDR_STAT) ? status_word : result;
  assign dataBus = rd_en ? rd_data : {BUS_W{1'bz}};

endmodule

// File: tb/tb_matrix_alu_seq.sv
// tb_matrix_alu_seq: table-driven directed bench for matrix_alu_seq (N=4, W=16),
// plus hand-written sequences for reset abort, busy-time commands, partial reads
// and bus release. Expectations follow MATRIX_ALU_SAT_EN when it is defined.
module tb_matrix_alu_seq;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int BUS_W = N * N * W;
  localparam int LIMIT = 400;

  localparam logic [15:0] BASE   = 16'h2000;
  localparam logic [15:0] A_SRC1 = BASE;
  localparam logic [15:0] A_SRC2 = BASE + 16'h0001;
  localparam logic [15:0] A_RES  = BASE + 16'h0D00;
  localparam logic [15:0] A_CMD  = BASE + 16'h0E00;
  localparam logic [15:0] A_STAT = BASE + 16'h0F00;

`ifdef MATRIX_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    string            name;
    logic [15:0]      op;
    logic [BUS_W-1:0] s1;
    logic [BUS_W-1:0] s2;
    logic [BUS_W-1:0] exp;
    int               cycles;
    bit               ovf;
  } vec_t;

  logic             clk     = 1'b0;
  logic             nReset  = 1'b1;
  logic [15:0]      address = 16'h0000;
  logic             nRead   = 1'b1;
  logic             nWrite  = 1'b1;
  logic             tb_oe   = 1'b0;
  logic [BUS_W-1:0] tb_dout = '0;
  wire  [BUS_W-1:0] data_bus;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[9];

  assign data_bus = tb_oe ? tb_dout : {BUS_W{1'bz}};

  matrix_alu_seq #(.N(N), .W(W), .BASE(BASE)) dut (
    .clk     (clk),
    .nReset  (nReset),
    .address (address),
    .nRead   (nRead),
    .nWrite  (nWrite),
    .dataBus (data_bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case anything stalls outside the bounded waits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [BUS_W-1:0] stat(input bit d, input bit b, input bit e, input bit o);
    logic [15:0] s;
    s = {8'(N), 4'b0000, o & SAT, e, b, d};
    return BUS_W'(s);
  endfunction

  task automatic write_reg(input logic [15:0] a, input logic [BUS_W-1:0] d);
    @(negedge clk);
    address = a;
    tb_dout = d;
    tb_oe   = 1'b1;
    nWrite  = 1'b0;
    @(posedge clk);
    #1;
    nWrite = 1'b1;
    tb_oe  = 1'b0;
  endtask

  task automatic read_reg(input logic [15:0] a, output logic [BUS_W-1:0] d);
    address = a;
    nRead   = 1'b0;
    #1;
    d     = data_bus;
    nRead = 1'b1;
  endtask

  task automatic check_output(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_released(input string name, input logic [BUS_W-1:0] act);
    checks++;
    if (!((act === {BUS_W{1'bz}}) || (act === {BUS_W{1'b0}}))) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected released bus", name, act);
    end
  endtask

  // Counts cycles with busy=1, sampling once per clock just after the edge.
  task automatic wait_done(output int cyc);
    logic [BUS_W-1:0] st;
    cyc = 0;
    for (int i = 0; i < LIMIT; i++) begin
      read_reg(A_STAT, st);
      if (!st[1]) break;
      cyc++;
      @(posedge clk);
      #1;
    end
    if (cyc >= LIMIT) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_done: busy still set after %0d cycles, expected done", cyc);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, output int cyc);
    write_reg(A_SRC1, v.s1);
    write_reg(A_SRC2, v.s2);
    write_reg(A_CMD, BUS_W'(v.op));
    wait_done(cyc);
  endtask

  task automatic build_vectors();
    logic [BUS_W-1:0] m1, m2, me;
    int v;
    for (int t = 0; t < 9; t++) begin
      m1 = '0; m2 = '0; me = '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          v = r * N + c;
          case (t)
            0: begin m1[v*W +: W] = (r == c) ? 16'd1 : 16'd0; m2[v*W +: W] = 16'(v + 256); me[v*W +: W] = 16'(v + 256); end
            1: begin m1[v*W +: W] = 16'd2;      m2[v*W +: W] = 16'd3;      me[v*W +: W] = 16'd24; end
            2: begin m1[v*W +: W] = 16'hFFFF;   m2[v*W +: W] = 16'd3;      me[v*W +: W] = 16'hFFF4; end
            3: begin m1[v*W +: W] = 16'h4000;   m2[v*W +: W] = 16'h0004;   me[v*W +: W] = SAT ? 16'h7FFF : 16'h0000; end
            4: begin m1[v*W +: W] = 16'h7FFF;   m2[v*W +: W] = 16'h0001;   me[v*W +: W] = SAT ? 16'h7FFF : 16'h8000; end
            5: begin m1[v*W +: W] = 16'(v);     m2[v*W +: W] = 16'd1;      me[v*W +: W] = 16'(v - 1); end
            6: begin m1[v*W +: W] = 16'h8000;   m2[v*W +: W] = 16'h0001;   me[v*W +: W] = SAT ? 16'h8000 : 16'h7FFF; end
            7: begin m1[v*W +: W] = 16'(v);     m2[v*W +: W] = 16'h00AA;   me[v*W +: W] = 16'(c * N + r); end
            default: begin
              m1[v*W +: W] = 16'(v);
              m2[v*W +: W] = (v == 0) ? 16'hFFFE : 16'h0005;
              me[v*W +: W] = 16'(-2 * v);
            end
          endcase
        end
      end
      vecs[t].s1  = m1;
      vecs[t].s2  = m2;
      vecs[t].exp = me;
    end
    vecs[0].name = "mul_ident"; vecs[0].op = 16'h2100; vecs[0].cycles = 64; vecs[0].ovf = 1'b0;
    vecs[1].name = "mul_small"; vecs[1].op = 16'h2100; vecs[1].cycles = 64; vecs[1].ovf = 1'b0;
    vecs[2].name = "mul_neg";   vecs[2].op = 16'h2100; vecs[2].cycles = 64; vecs[2].ovf = 1'b0;
    vecs[3].name = "mul_ovf";   vecs[3].op = 16'h2100; vecs[3].cycles = 64; vecs[3].ovf = 1'b1;
    vecs[4].name = "add_wrap";  vecs[4].op = 16'h2400; vecs[4].cycles = 16; vecs[4].ovf = 1'b1;
    vecs[5].name = "sub";       vecs[5].op = 16'h2500; vecs[5].cycles = 16; vecs[5].ovf = 1'b0;
    vecs[6].name = "sub_neg";   vecs[6].op = 16'h2500; vecs[6].cycles = 16; vecs[6].ovf = 1'b1;
    vecs[7].name = "trn";       vecs[7].op = 16'h2600; vecs[7].cycles = 16; vecs[7].ovf = 1'b0;
    vecs[8].name = "scl";       vecs[8].op = 16'h2700; vecs[8].cycles = 16; vecs[8].ovf = 1'b0;
  endtask

  // Main sequence: reset, abort, invalid opcode, vector table, busy-time corner cases.
  initial begin
    logic [BUS_W-1:0] rd, m1, m2, me, part;
    int cyc;

    build_vectors();

    #2 nReset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) nReset = 1'b1;
    @(posedge clk);
    #1;
    read_reg(A_STAT, rd);
    check_output("reset_status", rd, stat(0, 0, 0, 0));
    read_reg(A_RES, rd);
    check_output("reset_result", rd, '0);
    check_released("reset_bus_idle", data_bus);

    // Reset in the middle of a MUL aborts it and clears everything.
    write_reg(A_SRC1, vecs[0].s1);
    write_reg(A_SRC2, vecs[0].s2);
    write_reg(A_CMD, BUS_W'(16'h2100));
    repeat (10) begin @(posedge clk); #1; end
    read_reg(A_STAT, rd);
    check_output("mid_mul_busy", rd, stat(0, 1, 0, 0));
    nReset = 1'b0;
    #1;
    read_reg(A_STAT, rd);
    check_output("abort_status", rd, stat(0, 0, 0, 0));
    @(negedge clk) nReset = 1'b1;
    @(posedge clk);
    #1;
    read_reg(A_RES, rd);
    check_output("abort_result", rd, '0);
    check_released("abort_bus_idle", data_bus);

    // Read and write strobes together: the DUT must not drive.
    address = A_STAT;
    nRead   = 1'b0;
    nWrite  = 1'b0;
    #1;
    check_released("rd_wr_overlap", data_bus);
    nRead  = 1'b1;
    nWrite = 1'b1;

    // Invalid opcode when idle, then a scale that clears err.
    write_reg(A_CMD, BUS_W'(16'h2900));
    read_reg(A_STAT, rd);
    check_output("bad_op_status", rd, stat(0, 0, 1, 0));
    m1 = '0; m1[11*W +: W] = 16'd3;
    m2 = '0; m2[0 +: W] = 16'hFFFE;
    me = '0; me[11*W +: W] = 16'hFFFA;
    write_reg(A_SRC1, m1);
    write_reg(A_SRC2, m2);
    write_reg(A_CMD, BUS_W'(16'h2700));
    wait_done(cyc);
    check_int("scl_cycles", cyc, 16);
    read_reg(A_RES, rd);
    check_output("scl_result", rd, me);
    read_reg(A_STAT, rd);
    check_output("scl_status", rd, stat(1, 0, 0, 0));

    // Vector table.
    for (int t = 0; t < 9; t++) begin
      apply_stimulus(vecs[t], cyc);
      check_int({vecs[t].name, "_cycles"}, cyc, vecs[t].cycles);
      read_reg(A_STAT, rd);
      check_output({vecs[t].name, "_status"}, rd, stat(1, 0, 0, vecs[t].ovf));
      read_reg(A_RES, rd);
      check_output({vecs[t].name, "_result"}, rd, vecs[t].exp);
    end

    // Command while busy: flagged as error, transpose runs to completion.
    write_reg(A_SRC1, vecs[7].s1);
    write_reg(A_CMD, BUS_W'(16'h2600));
    repeat (2) begin @(posedge clk); #1; end
    write_reg(A_CMD, BUS_W'(16'h2500));
    read_reg(A_STAT, rd);
    check_output("busy_cmd_status", rd, stat(0, 1, 1, 0));
    wait_done(cyc);
    read_reg(A_RES, rd);
    check_output("trn_r1c0", BUS_W'(rd[(1*N+0)*W +: W]), BUS_W'(16'd1));
    check_output("trn_r0c1", BUS_W'(rd[(0*N+1)*W +: W]), BUS_W'(16'd4));
    check_output("busy_cmd_result", rd, vecs[7].exp);
    read_reg(A_STAT, rd);
    check_output("busy_cmd_done", rd, stat(1, 0, 1, 0));

    // Partial result during RUN, SRC1 write while busy, SRC1 not readable.
    m1 = '0; part = '0;
    for (int i = 0; i < N * N; i++) begin
      m1[i*W +: W] = 16'(i + 16);
      if (i < 5) part[i*W +: W] = 16'(i + 16);
    end
    write_reg(A_SRC1, m1);
    write_reg(A_SRC2, '0);
    write_reg(A_CMD, BUS_W'(16'h2400));
    repeat (5) begin @(posedge clk); #1; end
    read_reg(A_RES, rd);
    check_output("partial_result", rd, part);
    write_reg(A_SRC1, {(N*N){16'h1234}});
    read_reg(A_SRC1, rd);
    check_released("src1_read_bus", rd);
    wait_done(cyc);
    read_reg(A_RES, rd);
    check_output("src1_busy_write", rd, m1);
    read_reg(A_STAT, rd);
    check_output("final_status", rd, stat(1, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
